// File: rtl/sea_pkg.sv
// Shared SEA-96 definitions: widths, S-box, byte/word transforms and the core state enum.
package sea_pkg;

  localparam int unsigned ByteW     = 8;
  localparam int unsigned NB        = 6;
  localparam int unsigned HalfW     = ByteW * NB;
  localparam int unsigned NrDefault = 92;

  // Entry for 3-bit input v sits at bits [3v+2:3v].
  localparam logic [23:0] SboxTbl = {3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0};

  typedef logic [HalfW-1:0] half_t;

  typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;
  typedef enum logic {ModeKeyFwd, ModeKeyInv} mode_e;

  function automatic half_t badd(half_t a, half_t b);
    half_t y;
    for (int j = 0; j < NB; j++) begin
      y[j*ByteW +: ByteW] = a[j*ByteW +: ByteW] + b[j*ByteW +: ByteW];
    end
    return y;
  endfunction

  function automatic half_t sub_s(half_t x);
    half_t      y;
    logic [2:0] v;
    logic [2:0] o;
    y = '0;
    for (int t = 0; t < NB; t += 3) begin
      for (int k = 0; k < ByteW; k++) begin
        v = {x[(t+2)*ByteW+k], x[(t+1)*ByteW+k], x[t*ByteW+k]};
        o = SboxTbl[3*v +: 3];
        y[t*ByteW+k]     = o[0];
        y[(t+1)*ByteW+k] = o[1];
        y[(t+2)*ByteW+k] = o[2];
      end
    end
    return y;
  endfunction

  function automatic half_t rot_r(half_t x);
    half_t      y;
    logic [7:0] w0;
    logic [7:0] w2;
    for (int t = 0; t < NB; t += 3) begin
      w0 = x[t*ByteW +: ByteW];
      w2 = x[(t+2)*ByteW +: ByteW];
      y[t*ByteW +: ByteW]     = {w0[0], w0[7:1]};
      y[(t+1)*ByteW +: ByteW] = x[(t+1)*ByteW +: ByteW];
      y[(t+2)*ByteW +: ByteW] = {w2[6:0], w2[7]};
    end
    return y;
  endfunction

  function automatic half_t rot_w(half_t x);
    return {x[HalfW-ByteW-1:0], x[HalfW-1 -: ByteW]};
  endfunction

  function automatic half_t rot_w_inv(half_t x);
    return {x[ByteW-1:0], x[HalfW-1:ByteW]};
  endfunction

  function automatic half_t rc(logic [7:0] i);
    return half_t'(i);
  endfunction

endpackage

// File: rtl/sea_de_iter_if.sv
// Handshake and data bundle between the ciphertext source, the decryption core and the consumer.
interface sea_de_iter_if;
  import sea_pkg::*;

  logic  in_valid;
  logic  in_ready;
  half_t ct_l;
  half_t ct_r;
  half_t key_l;
  half_t key_r;
  logic  out_valid;
  logic  out_ready;
  half_t pt_l;
  half_t pt_r;
  logic  busy;

  modport master (
    output in_valid, ct_l, ct_r, key_l, key_r, out_ready,
    input  in_ready, out_valid, pt_l, pt_r, busy
  );

  modport slave (
    input  in_valid, ct_l, ct_r, key_l, key_r, out_ready,
    output in_ready, out_valid, pt_l, pt_r, busy
  );
endinterface

// File: rtl/sea_de_round.sv
// Combinational SEA-96 step: inverse Feistel round plus one key-schedule step, direction by mode_i.
module sea_de_round
  import sea_pkg::*;
(
  input  mode_e      mode_i,
  input  logic [7:0] cnt_i,
  input  half_t      l_i,
  input  half_t      r_i,
  input  half_t      kl_i,
  input  half_t      kr_i,
  output half_t      l_o,
  output half_t      r_o,
  output half_t      kl_o,
  output half_t      kr_o
);

  half_t k_src;
  half_t k_oth;
  half_t k_mix;

  always_comb begin
    k_src = (mode_i == ModeKeyInv) ? kl_i : kr_i;
    k_oth = (mode_i == ModeKeyInv) ? kr_i : kl_i;
    k_mix = k_oth ^ rot_w(rot_r(sub_s(badd(k_src, rc(cnt_i)))));
    kl_o  = (mode_i == ModeKeyInv) ? k_mix : kr_i;
    kr_o  = (mode_i == ModeKeyInv) ? kl_i  : k_mix;
    // Round key for the inverse round is KL_i, i.e. the key state before stepping back.
    r_o   = l_i;
    l_o   = rot_w_inv(r_i ^ rot_r(sub_s(badd(l_i, kl_i))));
  end

endmodule

// File: rtl/sea_de_iter.sv
// Iterative SEA-96 decryption core: forward key expansion, then one inverse round per clock.
// Optional expanded-key cache enabled by defining SEA_DE_KEY_CACHE_EN.
module sea_de_iter
  import sea_pkg::*;
#(
  parameter int unsigned NR = NrDefault
) (
  input logic          clk,
  input logic          rst_n,
  sea_de_iter_if.slave bus_io
);

  localparam logic [7:0] NrB = 8'(NR);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  half_t      l_q, l_d, r_q, r_d;
  half_t      kl_q, kl_d, kr_q, kr_d;
  half_t      rnd_l, rnd_r, rnd_kl, rnd_kr;

`ifdef SEA_DE_KEY_CACHE_EN
  logic [2*HalfW-1:0] cmk_q, cmk_d;
  half_t              ckl_q, ckl_d, ckr_q, ckr_d;
  logic               cvld_q, cvld_d;
  logic               hit;

  assign hit = cvld_q && ({bus_io.key_l, bus_io.key_r} == cmk_q);
`endif

  sea_de_round u_round (
    .mode_i (state_q == StDecrypt ? ModeKeyInv : ModeKeyFwd),
    .cnt_i  (cnt_q),
    .l_i    (l_q),
    .r_i    (r_q),
    .kl_i   (kl_q),
    .kr_i   (kr_q),
    .l_o    (rnd_l),
    .r_o    (rnd_r),
    .kl_o   (rnd_kl),
    .kr_o   (rnd_kr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    kl_d    = kl_q;
    kr_d    = kr_q;
`ifdef SEA_DE_KEY_CACHE_EN
    cmk_d   = cmk_q;
    ckl_d   = ckl_q;
    ckr_d   = ckr_q;
    cvld_d  = cvld_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          l_d     = bus_io.ct_l;
          r_d     = bus_io.ct_r;
          kl_d    = bus_io.key_l;
          kr_d    = bus_io.key_r;
          cnt_d   = 8'd1;
          state_d = StExpand;
`ifdef SEA_DE_KEY_CACHE_EN
          if (hit) begin
            kl_d    = ckl_q;
            kr_d    = ckr_q;
            cnt_d   = NrB;
            state_d = StDecrypt;
          end else begin
            cmk_d  = {bus_io.key_l, bus_io.key_r};
            cvld_d = 1'b0;
          end
`endif
        end
      end
      StExpand: begin
        kl_d = rnd_kl;
        kr_d = rnd_kr;
        if (cnt_q == NrB) begin
          state_d = StDecrypt;
`ifdef SEA_DE_KEY_CACHE_EN
          ckl_d  = rnd_kl;
          ckr_d  = rnd_kr;
          cvld_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDecrypt: begin
        l_d  = rnd_l;
        r_d  = rnd_r;
        kl_d = rnd_kl;
        kr_d = rnd_kr;
        if (cnt_q == 8'd1) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      kl_q    <= '0;
      kr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      kl_q    <= kl_d;
      kr_q    <= kr_d;
    end
  end

`ifdef SEA_DE_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmk_q  <= '0;
      ckl_q  <= '0;
      ckr_q  <= '0;
      cvld_q <= 1'b0;
    end else begin
      cmk_q  <= cmk_d;
      ckl_q  <= ckl_d;
      ckr_q  <= ckr_d;
      cvld_q <= cvld_d;
    end
  end
`endif

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.pt_l      = l_q;
  assign bus_io.pt_r      = r_q;

endmodule

// File: tb/tb_sea_de_iter.sv
// Self-checking bench for sea_de_iter against a forward SEA-96 encryption model.
module tb_sea_de_iter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sea_de_iter_if bus92 ();
  sea_de_iter_if bus2 ();

  sea_de_iter #(.NR(92)) u_dut (.clk(clk), .rst_n(rst_n), .bus_io(bus92));
  sea_de_iter #(.NR(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus_io(bus2));

  function automatic logic [2:0] m_sb(input logic [2:0] v);
    case (v)
      3'd0: return 3'd0;
      3'd1: return 3'd5;
      3'd2: return 3'd6;
      3'd3: return 3'd7;
      3'd4: return 3'd4;
      3'd5: return 3'd3;
      3'd6: return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  // r(S(x byte-add k))
  function automatic logic [47:0] m_f(input logic [47:0] x, input logic [47:0] k);
    logic [7:0]  b [6];
    logic [7:0]  o [6];
    logic [2:0]  s;
    logic [47:0] y;
    for (int j = 0; j < 6; j++) b[j] = x[8*j +: 8] + k[8*j +: 8];
    for (int t = 0; t < 2; t++) begin
      for (int q = 0; q < 8; q++) begin
        s = m_sb({b[3*t+2][q], b[3*t+1][q], b[3*t][q]});
        o[3*t][q]   = s[0];
        o[3*t+1][q] = s[1];
        o[3*t+2][q] = s[2];
      end
      o[3*t]   = (o[3*t] >> 1) | (o[3*t] << 7);
      o[3*t+2] = (o[3*t+2] << 1) | (o[3*t+2] >> 7);
    end
    for (int j = 0; j < 6; j++) y[8*j +: 8] = o[j];
    return y;
  endfunction

  function automatic logic [47:0] m_wrot(input logic [47:0] x);
    logic [47:0] y;
    for (int j = 0; j < 6; j++) y[8*((j+1)%6) +: 8] = x[8*j +: 8];
    return y;
  endfunction

  task automatic m_enc(input logic [47:0] pl, input logic [47:0] pr, input logic [47:0] kl_in,
                       input logic [47:0] kr_in, input int rounds,
                       output logic [47:0] cl, output logic [47:0] cr);
    logic [47:0] l, r, kl, kr, t, nl;
    l = pl; r = pr; kl = kl_in; kr = kr_in;
    for (int i = 1; i <= rounds; i++) begin
      t  = kl;
      kl = kr;
      kr = t ^ m_wrot(m_f(kl, {40'd0, 8'(i)}));
      nl = r;
      r  = m_wrot(l) ^ m_f(nl, kl);
      l  = nl;
    end
    cl = l; cr = r;
  endtask

  // Present one block to the NR=92 core, return latency and plaintext; optionally acknowledge.
  task automatic run92(input logic [47:0] cl, input logic [47:0] cr, input logic [47:0] kl,
                       input logic [47:0] kr, input bit ack,
                       output int lat, output logic [47:0] ol, output logic [47:0] orr);
    bus92.ct_l = cl; bus92.ct_r = cr; bus92.key_l = kl; bus92.key_r = kr;
    bus92.in_valid = 1'b1;
    @(posedge clk); #1;
    bus92.in_valid = 1'b0;
    lat = 0;
    while (!bus92.out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    ol = bus92.pt_l; orr = bus92.pt_r;
    if (ack) begin
      bus92.out_ready = 1'b1;
      @(posedge clk); #1;
      bus92.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus92.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus92.in_ready); else passed++;
    checks++; if (bus92.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus92.out_valid); else passed++;
    checks++; if (bus92.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus92.busy); else passed++;
    checks++; if ({bus92.pt_l, bus92.pt_r} !== 96'd0) $display("FAIL rst_pt got %h want 0", {bus92.pt_l, bus92.pt_r}); else passed++;
    checks++; if (bus2.in_ready !== 1'b1) $display("FAIL rst_in_ready2 got %b want 1", bus2.in_ready); else passed++;
  endtask

  task automatic test_zero();
    logic [47:0] cl, cr, ol, orr;
    int lat;
    m_enc(48'd0, 48'd0, 48'd0, 48'd0, 92, cl, cr);
    run92(cl, cr, 48'd0, 48'd0, 1'b1, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL zero_latency got %0d want 184", lat); else passed++;
    checks++; if (ol !== 48'd0) $display("FAIL zero_pt_l got %h want 0", ol); else passed++;
    checks++; if (orr !== 48'd0) $display("FAIL zero_pt_r got %h want 0", orr); else passed++;
    checks++; if (bus92.out_valid !== 1'b0) $display("FAIL zero_ov_drop got %b want 0", bus92.out_valid); else passed++;
    checks++; if (bus92.in_ready !== 1'b1) $display("FAIL zero_ir_back got %b want 1", bus92.in_ready); else passed++;
  endtask

  task automatic test_hold();
    logic [47:0] pl, pr, cl, cr, ol, orr;
    int lat;
    pl = 48'h0123456789AB; pr = 48'hCDEF01234567;
    m_enc(pl, pr, 48'hFFFFFFFFFFFF, 48'h000000000000, 92, cl, cr);
    run92(cl, cr, 48'hFFFFFFFFFFFF, 48'h000000000000, 1'b0, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL hold_latency got %0d want 184", lat); else passed++;
    for (int c = 0; c < 10; c++) begin
      checks++; if ({bus92.pt_l, bus92.pt_r} !== {pl, pr}) $display("FAIL hold_pt cyc %0d got %h want %h", c, {bus92.pt_l, bus92.pt_r}, {pl, pr}); else passed++;
      checks++; if ({bus92.out_valid, bus92.in_ready, bus92.busy} !== 3'b101) $display("FAIL hold_ctl cyc %0d got %b want 101", c, {bus92.out_valid, bus92.in_ready, bus92.busy}); else passed++;
      @(posedge clk); #1;
    end
    bus92.out_ready = 1'b1;
    @(posedge clk); #1;
    bus92.out_ready = 1'b0;
    checks++; if (bus92.in_ready !== 1'b1) $display("FAIL hold_release got %b want 1", bus92.in_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [47:0] cl, cr, ol, orr;
    int lat;
    bit rose;
    bus92.ct_l = 48'h111111111111; bus92.ct_r = 48'h222222222222;
    bus92.key_l = 48'h333333333333; bus92.key_r = 48'h444444444444;
    bus92.in_valid = 1'b1;
    @(posedge clk); #1;
    bus92.in_valid = 1'b0;
    rose = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus92.out_valid) rose = 1'b1;
    end
    rst_n = 1'b0;
    #2;
    checks++; if ({bus92.in_ready, bus92.busy} !== 2'b10) $display("FAIL rstmid_async got %b want 10", {bus92.in_ready, bus92.busy}); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus92.out_valid) rose = 1'b1;
    end
    checks++; if (rose !== 1'b0) $display("FAIL rstmid_no_output got %b want 0", rose); else passed++;
    checks++; if (bus92.in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", bus92.in_ready); else passed++;
    m_enc(48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 48'h0F0F0F0F0F0F, 48'hF0F0F0F0F0F0, 92, cl, cr);
    run92(cl, cr, 48'h0F0F0F0F0F0F, 48'hF0F0F0F0F0F0, 1'b1, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL rstmid_next_latency got %0d want 184", lat); else passed++;
    checks++; if ({ol, orr} !== {48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A}) $display("FAIL rstmid_next_pt got %h want a5a5a5a5a5a55a5a5a5a5a5a", {ol, orr}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [47:0] ca_l, ca_r, cb_l, cb_r;
    int lat;
    m_enc(48'hDEADBEEF0001, 48'hCAFEF00D0002, 48'h123456789ABC, 48'hFEDCBA987654, 92, ca_l, ca_r);
    m_enc(48'h000000000003, 48'hFFFFFFFFFFFC, 48'h0A0B0C0D0E0F, 48'h102030405060, 92, cb_l, cb_r);
    bus92.ct_l = ca_l; bus92.ct_r = ca_r; bus92.key_l = 48'h123456789ABC; bus92.key_r = 48'hFEDCBA987654;
    bus92.in_valid = 1'b1;
    bus92.out_ready = 1'b1;
    @(posedge clk); #1;
    // Next block's data appears right after acceptance; the core must ignore it.
    bus92.ct_l = cb_l; bus92.ct_r = cb_r; bus92.key_l = 48'h0A0B0C0D0E0F; bus92.key_r = 48'h102030405060;
    lat = 0;
    while (!bus92.out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 184) $display("FAIL b2b_a_latency got %0d want 184", lat); else passed++;
    checks++; if ({bus92.pt_l, bus92.pt_r} !== {48'hDEADBEEF0001, 48'hCAFEF00D0002}) $display("FAIL b2b_a_pt got %h want deadbeef0001cafef00d0002", {bus92.pt_l, bus92.pt_r}); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus92.out_valid, bus92.in_ready} !== 2'b01) $display("FAIL b2b_handshake got %b want 01", {bus92.out_valid, bus92.in_ready}); else passed++;
    @(posedge clk); #1;
    bus92.in_valid = 1'b0;
    checks++; if ({bus92.busy, bus92.in_ready} !== 2'b10) $display("FAIL b2b_second_accept got %b want 10", {bus92.busy, bus92.in_ready}); else passed++;
    lat = 0;
    while (!bus92.out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 184) $display("FAIL b2b_b_latency got %0d want 184", lat); else passed++;
    checks++; if ({bus92.pt_l, bus92.pt_r} !== {48'h000000000003, 48'hFFFFFFFFFFFC}) $display("FAIL b2b_b_pt got %h want 000000000003fffffffffffc", {bus92.pt_l, bus92.pt_r}); else passed++;
    @(posedge clk); #1;
    bus92.out_ready = 1'b0;
  endtask

  task automatic test_nr2_random();
    logic [47:0] pl, pr, kl, kr, cl, cr;
    int lat;
    int bad_lat;
    int bad_pt;
    bad_lat = 0; bad_pt = 0;
    bus2.out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      pl = {16'($urandom), 32'($urandom)}; pr = {16'($urandom), 32'($urandom)};
      kl = {16'($urandom), 32'($urandom)}; kr = {16'($urandom), 32'($urandom)};
      m_enc(pl, pr, kl, kr, 2, cl, cr);
      bus2.ct_l = cl; bus2.ct_r = cr; bus2.key_l = kl; bus2.key_r = kr;
      bus2.in_valid = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      lat = 0;
      while (!bus2.out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 4) begin
        bad_lat++;
        if (bad_lat <= 5) $display("FAIL nr2_latency blk %0d got %0d want 4", n, lat);
      end else passed++;
      checks++;
      if ({bus2.pt_l, bus2.pt_r} !== {pl, pr}) begin
        bad_pt++;
        if (bad_pt <= 5) $display("FAIL nr2_pt blk %0d got %h want %h", n, {bus2.pt_l, bus2.pt_r}, {pl, pr});
      end else passed++;
      @(posedge clk); #1;
    end
    bus2.out_ready = 1'b0;
  endtask

`ifdef SEA_DE_KEY_CACHE_EN
  task automatic test_cache();
    logic [47:0] cl, cr, ol, orr;
    int lat;
    m_enc(48'h1, 48'h2, 48'hABCDEF012345, 48'h6789ABCDEF01, 92, cl, cr);
    run92(cl, cr, 48'hABCDEF012345, 48'h6789ABCDEF01, 1'b1, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL cache_first_latency got %0d want 184", lat); else passed++;
    m_enc(48'h777, 48'h888, 48'hABCDEF012345, 48'h6789ABCDEF01, 92, cl, cr);
    run92(cl, cr, 48'hABCDEF012345, 48'h6789ABCDEF01, 1'b1, lat, ol, orr);
    checks++; if (lat !== 92) $display("FAIL cache_hit_latency got %0d want 92", lat); else passed++;
    checks++; if ({ol, orr} !== {48'h777, 48'h888}) $display("FAIL cache_hit_pt got %h want %h", {ol, orr}, {48'h777, 48'h888}); else passed++;
    m_enc(48'h999, 48'hAAA, 48'h55AA55AA55AA, 48'hAA55AA55AA55, 92, cl, cr);
    run92(cl, cr, 48'h55AA55AA55AA, 48'hAA55AA55AA55, 1'b1, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL cache_miss_latency got %0d want 184", lat); else passed++;
    checks++; if ({ol, orr} !== {48'h999, 48'hAAA}) $display("FAIL cache_miss_pt got %h want %h", {ol, orr}, {48'h999, 48'hAAA}); else passed++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_enc(48'hBBB, 48'hCCC, 48'h55AA55AA55AA, 48'hAA55AA55AA55, 92, cl, cr);
    run92(cl, cr, 48'h55AA55AA55AA, 48'hAA55AA55AA55, 1'b1, lat, ol, orr);
    checks++; if (lat !== 184) $display("FAIL cache_after_reset_latency got %0d want 184", lat); else passed++;
    checks++; if ({ol, orr} !== {48'hBBB, 48'hCCC}) $display("FAIL cache_after_reset_pt got %h want %h", {ol, orr}, {48'hBBB, 48'hCCC}); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus92.in_valid = 1'b0; bus92.out_ready = 1'b0;
    bus92.ct_l = '0; bus92.ct_r = '0; bus92.key_l = '0; bus92.key_r = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus2.ct_l = '0; bus2.ct_r = '0; bus2.key_l = '0; bus2.key_r = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_zero();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_nr2_random();
`ifdef SEA_DE_KEY_CACHE_EN
    test_cache();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
